gray_scan_engine: RTL

GRAY_SCAN_ENGINE -- requirements
Module: gray_scan_engine

---
 rtl/gray_scan_if.sv | 28 ++
 rtl/gray_scan_engine.sv | 136 +++++++++++++
 2 files changed

// File: rtl/gray_scan_if.sv
// Bus bundle between the scan engine, the gray source memory and the
// filtered-result sink. The engine is the master: it issues reads and
// emits result writes. The memory/sink side uses the slave modport.
interface gray_scan_if #(
    parameter int In_Width   = 8,
    parameter int Out_Width  = 9,
    parameter int Addr_Width = 16
);
    logic [1:0]            mode;
    logic                  gray_ready;
    logic                  gray_req;
    logic [Addr_Width-1:0] gray_addr;
    logic [In_Width-1:0]   gray_data;
    logic                  ipf_valid;
    logic [Addr_Width-1:0] ipf_addr;
    logic [Out_Width-1:0]  ipf_data;
    logic                  finish;

    modport master (
        input  mode, gray_ready, gray_data,
        output gray_req, gray_addr, ipf_valid, ipf_addr, ipf_data, finish
    );

    modport slave (
        output mode, gray_ready, gray_data,
        input  gray_req, gray_addr, ipf_valid, ipf_addr, ipf_data, finish
    );
endinterface

// File: rtl/gray_scan_engine.sv
// Raster-scan filter engine. Reads one 256x256 gray frame pixel by pixel in
// ascending address order, applies a horizontal neighbour filter selected
// at frame start, and writes one result per accepted pixel one cycle later.
// After the last pixel the engine parks in DONE with finish held high.
module gray_scan_engine #(
    parameter int In_Width   = 8,
    parameter int Out_Width  = 9,
    parameter int Addr_Width = 16
) (
    input logic         clk,
    input logic         rst,
    gray_scan_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [Addr_Width-1:0] LastAddr = '1;

    state_t                state;
    state_t                state_next;
    logic [1:0]            mode_r;
    logic [Addr_Width-1:0] cnt;
    logic [In_Width-1:0]   q_r;
    logic                  sample;
    logic                  row_start;
    logic [Out_Width-1:0]  p_ext;
    logic [Out_Width-1:0]  q_ext;
    logic [Out_Width-1:0]  result;
    logic                  out_valid;
    logic [Addr_Width-1:0] out_addr;
    logic [Out_Width-1:0]  out_data;

    // Column 0 of every row has no left neighbour.
    assign row_start = (cnt[7:0] == 8'd0);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and read-request generation.
    // NOTE: every output of a combinational block gets a default first,
    // otherwise paths that skip an assignment infer latches.
    always_comb begin
        state_next = state;
        sample     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.gray_ready) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                sample = bus.gray_ready;
                if (bus.gray_ready && (cnt == LastAddr)) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                state_next = DONE;
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Frame setup at start, then address advance and left-neighbour capture
    // on every accepted read; the counter saturates on the final pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r <= 2'd0;
            cnt    <= '0;
            q_r    <= '0;
        end else if (state == IDLE) begin
            if (bus.gray_ready) begin
                mode_r <= bus.mode;
                cnt    <= '0;
                q_r    <= '0;
            end
        end else if (sample) begin
            q_r <= bus.gray_data;
            if (cnt != LastAddr) begin
                cnt <= cnt + Addr_Width'(1);
            end
        end
    end

    // Filter datapath on the pixel currently being read.
    always_comb begin
        p_ext = Out_Width'(bus.gray_data);
        q_ext = row_start ? '0 : Out_Width'(q_r);
        case (mode_r)
            2'd1:    result = p_ext + q_ext;
            2'd2:    result = (p_ext >= q_ext) ? (p_ext - q_ext) : (q_ext - p_ext);
            default: result = p_ext;
        endcase
    end

    // One registered output stage: result appears the cycle after its read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= sample;
            if (sample) begin
                out_addr <= cnt;
                out_data <= result;
            end
        end
    end

    assign bus.gray_req  = sample;
    assign bus.gray_addr = cnt;
    assign bus.ipf_valid = out_valid;
    assign bus.ipf_addr  = out_addr;
    assign bus.ipf_data  = out_data;
    assign bus.finish    = (state == DONE);

endmodule
